// File: rtl/uart_rx_majority_sampler_if.sv
// Bundle between the bit/edge counter, the RX FSM and the majority sampler.
// The sampler takes the slave side; whoever drives RX_IN, the config and edg_cnt takes the master side.
interface uart_rx_majority_sampler_if #(
  parameter int PRESCALE_WIDTH = 6
);
  logic                      RX_IN;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic [PRESCALE_WIDTH-1:0] edg_cnt;
  logic                      Enable;
  logic [1:0]                Num_Samples;
  logic                      Sbit;
  logic                      Sbit_vld;
  logic                      Noise_err;
  logic                      Cfg_err;

  modport master (
    output RX_IN, Prescale, edg_cnt, Enable, Num_Samples,
    input  Sbit, Sbit_vld, Noise_err, Cfg_err
  );

  modport slave (
    input  RX_IN, Prescale, edg_cnt, Enable, Num_Samples,
    output Sbit, Sbit_vld, Noise_err, Cfg_err
  );
endinterface

// File: rtl/uart_rx_majority_sampler.sv
// Majority-vote bit decision over 1/3/5/7 samples centred on the bit midpoint.
// The config is latched when Enable rises; an illegal config falls back to one sample at the centre.
module uart_rx_majority_sampler #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int MAX_SAMPLES    = 7,
  parameter int SYNC_STAGES    = 2
) (
  input logic                       CLK,
  input logic                       RST,
  uart_rx_majority_sampler_if.slave bus
);
  localparam int         PW    = PRESCALE_WIDTH;
  localparam int         XW    = PRESCALE_WIDTH + 1;
  localparam logic [2:0] MAX_N = 3'(MAX_SAMPLES);

  logic rx_sync;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign rx_sync = bus.RX_IN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [SYNC_STAGES-1:0] sync_next;
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          assign sync_next[gi] = bus.RX_IN;
        end else begin : g_tail
          assign sync_next[gi] = sync_reg[gi-1];
        end
      end
      // Idle-high reset so the line does not look like a start bit after reset.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sync_reg <= '1;
        else      sync_reg <= sync_next;
      end
      assign rx_sync = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic [2:0]    req_n, cnt_n, n_new;
  logic          clamp, err_new;
  logic [XW-1:0] k_x, c_x, p_x;
  logic [PW-1:0] lo_new, hi_new;

  assign req_n = {bus.Num_Samples, 1'b1};
  assign clamp = (req_n > MAX_N);
  assign cnt_n = clamp ? MAX_N : req_n;
  assign k_x   = XW'(cnt_n >> 1);
  assign p_x   = XW'(bus.Prescale);
  assign c_x   = (p_x >> 1) - XW'(1);

  always_comb begin
    lo_new  = '0;
    hi_new  = '0;
    n_new   = 3'd1;
    err_new = 1'b1;
    if (p_x >= XW'(2)) begin
      if (!clamp && (k_x <= c_x) && ((c_x + k_x) <= (p_x - XW'(1)))) begin
        lo_new  = PW'(c_x - k_x);
        hi_new  = PW'(c_x + k_x);
        n_new   = cnt_n;
        err_new = 1'b0;
      end else begin
        lo_new = PW'(c_x);
        hi_new = PW'(c_x);
      end
    end
  end

  logic          en_d_reg, cfg_err_reg, rise;
  logic [PW-1:0] lo_reg, hi_reg, lo_eff, hi_eff;
  logic [2:0]    n_reg, n_eff;

  // The rising-edge cycle already samples with the freshly derived window.
  assign rise   = bus.Enable & ~en_d_reg;
  assign lo_eff = rise ? lo_new : lo_reg;
  assign hi_eff = rise ? hi_new : hi_reg;
  assign n_eff  = rise ? n_new  : n_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_d_reg    <= 1'b0;
      lo_reg      <= '0;
      hi_reg      <= '0;
      n_reg       <= 3'd1;
      cfg_err_reg <= 1'b0;
    end else begin
      en_d_reg <= bus.Enable;
      if (rise) begin
        lo_reg      <= lo_new;
        hi_reg      <= hi_new;
        n_reg       <= n_new;
        cfg_err_reg <= err_new;
      end
    end
  end

  logic [2:0] ones_reg, zeros_reg, ones_next, zeros_next, ones_base, zeros_base;
  logic [3:0] ones_tot, zeros_tot;
  logic       in_window;
  logic       sbit_reg, sbit_next, vld_reg, vld_next, noise_reg, noise_next;

  assign in_window  = (bus.edg_cnt >= lo_eff) && (bus.edg_cnt <= hi_eff);
  assign ones_base  = (bus.edg_cnt == '0) ? 3'd0 : ones_reg;
  assign zeros_base = (bus.edg_cnt == '0) ? 3'd0 : zeros_reg;
  assign ones_tot   = {1'b0, ones_base}  + {3'b000, rx_sync};
  assign zeros_tot  = {1'b0, zeros_base} + {3'b000, ~rx_sync};

  // A strobe needs the full sample count, so a window entered part-way never decides.
  always_comb begin
    ones_next  = '0;
    zeros_next = '0;
    sbit_next  = sbit_reg;
    noise_next = noise_reg;
    vld_next   = 1'b0;
    if (bus.Enable) begin
      if (!in_window) begin
        ones_next  = ones_base;
        zeros_next = zeros_base;
      end else if (bus.edg_cnt != hi_eff) begin
        ones_next  = ones_tot[2:0];
        zeros_next = zeros_tot[2:0];
      end else if ((ones_tot + zeros_tot) == {1'b0, n_eff}) begin
        vld_next   = 1'b1;
        sbit_next  = (ones_tot > zeros_tot);
        noise_next = (ones_tot != 4'd0) && (zeros_tot != 4'd0);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ones_reg  <= '0;
      zeros_reg <= '0;
      sbit_reg  <= 1'b1;
      vld_reg   <= 1'b0;
      noise_reg <= 1'b0;
    end else begin
      ones_reg  <= ones_next;
      zeros_reg <= zeros_next;
      sbit_reg  <= sbit_next;
      vld_reg   <= vld_next;
      noise_reg <= noise_next;
    end
  end

  assign bus.Sbit      = sbit_reg;
  assign bus.Sbit_vld  = vld_reg;
  assign bus.Noise_err = noise_reg;
  assign bus.Cfg_err   = cfg_err_reg;
endmodule

// File: tb/tb_uart_rx_majority_sampler.sv
// Bench for uart_rx_majority_sampler: directed bit scenarios plus randomized bits,
// checked every cycle against a window-level model built from the line history.
module tb_uart_rx_majority_sampler;
  localparam int PW   = 6;
  localparam int MAXS = 7;
  localparam int SYNC = 2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_rx_majority_sampler_if #(.PRESCALE_WIDTH(PW)) bus ();

  uart_rx_majority_sampler #(
    .PRESCALE_WIDTH(PW),
    .MAX_SAMPLES   (MAXS),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int dut_strobes = 0;
  int n_bits = 0;

  // Model state
  int m_lo, m_hi, m_n;
  bit m_err = 1'b0;
  bit m_sbit = 1'b1;
  bit m_noise = 1'b0;
  bit m_en_prev = 1'b0;
  bit hist[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line value the sampler sees at a given cycle index (sync flops reset to idle-high).
  function automatic bit seen(input int idx);
    if (idx < 0) return 1'b1;
    return hist[idx];
  endfunction

  function automatic void model_cfg(input int p, input int ns);
    int req, nn, k, c;
    req = 2 * ns + 1;
    nn  = (req > MAXS) ? MAXS : req;
    k   = (nn - 1) / 2;
    if (p < 2) begin
      m_err = 1'b1; m_lo = 0; m_hi = 0; m_n = 1;
    end else begin
      c = p / 2 - 1;
      if (req > MAXS || k > c || c + k > p - 1) begin
        m_err = 1'b1; m_lo = c; m_hi = c; m_n = 1;
      end else begin
        m_err = 1'b0; m_lo = c - k; m_hi = c + k; m_n = nn;
      end
    end
  endfunction

  function automatic logic [63:0] mk_bits(input bit v, input bit noisy);
    logic [63:0] m;
    m = noisy ? ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}) : 64'd0;
    return {64{v}} ^ m;
  endfunction

  function automatic int last_of(input int p);
    return (p < 2) ? 0 : p - 1;
  endfunction

  task automatic check_outputs(input bit exp_vld);
    if (bus.Sbit_vld === 1'b1) dut_strobes++;
    check_val("vld", bus.Sbit_vld, exp_vld);
    check_val("sbit", bus.Sbit, m_sbit);
    check_val("noise", bus.Noise_err, m_noise);
    check_val("cfg_err", bus.Cfg_err, m_err);
  endtask

  task automatic idle(input int cycles, input bit rx);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      bus.Enable      = 1'b0;
      bus.edg_cnt     = PW'($urandom);
      bus.RX_IN       = rx;
      bus.Prescale    = PW'($urandom);
      bus.Num_Samples = 2'($urandom);
      hist.push_back(rx);
      m_en_prev = 1'b0;
      @(posedge CLK); #1;
      check_outputs(1'b0);
    end
  endtask

  // Drives edg_cnt first..last of one bit with Enable high; RX_IN leads by SYNC cycles
  // so rxv[q] is roughly the sample seen at position q.
  task automatic run_bit(input int p, input int ns, input logic [63:0] rxv,
                         input int first, input int last);
    int jidx[64];
    int ones;
    bit exp_vld, rise;
    for (int e = first; e <= last; e++) begin
      rise = !m_en_prev && (e == first);
      if (rise) model_cfg(p, ns);
      @(negedge CLK);
      bus.Enable      = 1'b1;
      bus.edg_cnt     = PW'(e);
      bus.RX_IN       = rxv[(e + SYNC) % 64];
      bus.Prescale    = rise ? PW'(p) : PW'($urandom);
      bus.Num_Samples = rise ? 2'(ns) : 2'($urandom);
      hist.push_back(bus.RX_IN);
      jidx[e] = hist.size() - 1;
      m_en_prev = 1'b1;
      @(posedge CLK); #1;
      exp_vld = (e == m_hi) && (first <= m_lo);
      if (exp_vld) begin
        ones = 0;
        for (int q = m_lo; q <= m_hi; q++) ones += int'(seen(jidx[q] - SYNC));
        m_sbit  = (2 * ones > m_n);
        m_noise = (ones != 0) && (ones != m_n);
        n_bits++;
        $display("bit %0d: P=%0d N=%0d ones=%0d -> sbit=%0b noise=%0b cfg_err=%0b (dut %0b/%0b/%0b)",
                 n_bits, p, m_n, ones, m_sbit, m_noise, m_err, bus.Sbit, bus.Noise_err, bus.Cfg_err);
      end
      check_outputs(exp_vld);
    end
  endtask

  int s0, cur_p, cur_ns, p, ns, mode, first, stop;
  int plist[8] = '{0, 1, 2, 3, 5, 8, 16, 63};

  initial begin
    bus.Enable = 1'b0; bus.RX_IN = 1'b1; bus.Prescale = PW'(8);
    bus.Num_Samples = 2'd0; bus.edg_cnt = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_val("rst_sbit", bus.Sbit, 1'b1);
    check_val("rst_vld", bus.Sbit_vld, 1'b0);
    check_val("rst_noise", bus.Noise_err, 1'b0);
    check_val("rst_cfg_err", bus.Cfg_err, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    hist.push_back(1'b1);

    // 1: P=8, N=3, samples 1,0,1
    idle(3, 1'b1);
    s0 = dut_strobes;
    run_bit(8, 1, ~64'h8, 0, 7);
    check_val("t1_sbit", bus.Sbit, 1'b1);
    check_val("t1_noise", bus.Noise_err, 1'b1);
    check_val("t1_strobes", dut_strobes - s0, 1);

    // 2: P=16, N=5, samples 0,0,1,0,0 then all zero
    idle(2, 1'b0);
    run_bit(16, 2, 64'h80, 0, 15);
    check_val("t2a_sbit", bus.Sbit, 1'b0);
    check_val("t2a_noise", bus.Noise_err, 1'b1);
    run_bit(16, 2, 64'h0, 0, 15);
    check_val("t2b_sbit", bus.Sbit, 1'b0);
    check_val("t2b_noise", bus.Noise_err, 1'b0);

    // 3: P=4, N=5 illegal -> one sample at position 1
    idle(3, 1'b1);
    run_bit(4, 2, 64'h0, 0, 3);
    check_val("t3_cfg_err", bus.Cfg_err, 1'b1);
    check_val("t3_sbit", bus.Sbit, 1'b1);
    check_val("t3_noise", bus.Noise_err, 1'b0);

    // 4: P=32, N=7, ten alternating bits
    idle(2, 1'b1);
    s0 = dut_strobes;
    for (int b = 0; b < 10; b++) run_bit(32, 3, mk_bits(b[0], 1'b0), 0, 31);
    check_val("t4_strobes", dut_strobes - s0, 10);
    check_val("t4_cfg_err", bus.Cfg_err, 1'b0);

    // 5: enable dropped after two of three samples
    idle(2, 1'b1);
    s0 = dut_strobes;
    run_bit(8, 1, mk_bits(1'b1, 1'b0), 0, 3);
    idle(1, 1'b0);
    check_val("t5_abort", dut_strobes - s0, 0);
    run_bit(8, 1, 64'h0, 0, 7);
    check_val("t5_strobes", dut_strobes - s0, 1);
    check_val("t5_sbit", bus.Sbit, 1'b0);

    // 6: reset mid-window
    idle(2, 1'b1);
    run_bit(16, 2, 64'h80, 0, 15);
    idle(1, 1'b0);
    run_bit(4, 2, 64'h0, 0, 0);
    #3;
    RST = 1'b0;
    bus.Enable = 1'b0;
    bus.RX_IN = 1'b1;
    #1;
    check_val("t6_sbit", bus.Sbit, 1'b1);
    check_val("t6_vld", bus.Sbit_vld, 1'b0);
    check_val("t6_noise", bus.Noise_err, 1'b0);
    check_val("t6_cfg_err", bus.Cfg_err, 1'b0);
    m_sbit = 1'b1; m_noise = 1'b0; m_err = 1'b0; m_en_prev = 1'b0;
    @(posedge CLK); #1;
    check_val("t6_vld_hold", bus.Sbit_vld, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    hist.delete();
    hist.push_back(1'b1);
    s0 = dut_strobes;
    run_bit(16, 1, mk_bits(1'b1, 1'b0), 7, 15);
    check_val("t6_partial", dut_strobes - s0, 0);
    run_bit(16, 1, 64'h0, 0, 15);
    check_val("t6_strobes", dut_strobes - s0, 1);
    check_val("t6_sbit_after", bus.Sbit, 1'b0);
    cur_p = 16; cur_ns = 1;

    // Randomized bits
    for (int it = 0; it < 80; it++) begin
      mode = $urandom_range(0, 3);
      if (mode == 0 && !m_en_prev) mode = 1;
      p  = plist[$urandom_range(0, 7)];
      ns = $urandom_range(0, 3);
      case (mode)
        0: run_bit(cur_p, cur_ns, mk_bits(1'($urandom), 1'($urandom)), 0, last_of(cur_p));
        1: begin
          idle($urandom_range(1, 3), 1'($urandom));
          run_bit(p, ns, mk_bits(1'($urandom), 1'($urandom)), 0, last_of(p));
          cur_p = p; cur_ns = ns;
        end
        2: begin
          idle($urandom_range(1, 3), 1'($urandom));
          first = $urandom_range(0, last_of(p));
          run_bit(p, ns, mk_bits(1'($urandom), 1'($urandom)), first, last_of(p));
          cur_p = p; cur_ns = ns;
        end
        default: begin
          idle(1, 1'($urandom));
          stop = $urandom_range(0, last_of(p));
          run_bit(p, ns, mk_bits(1'($urandom), 1'($urandom)), 0, stop);
          idle($urandom_range(1, 2), 1'($urandom));
          cur_p = p; cur_ns = ns;
        end
      endcase
    end

    idle(2, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
